fiber_iq_tx: RTL
================

// Module: fiber_iq_tx
// PURPOSE
//  Transmit end of the fiber I/Q link: the receiving chassis consumes iq_recv[16:0]/qsync_rx.
//  - Takes local downconverted field samples (interleaved X/Y, 18-bit) and rounds/saturates them to 17 bits.
//  - Frames them on an 8-cycle grid and emits a qsync marker, which the far end uses to reset its 3-bit I/Q state divider.
//  - Sits between fdownconvert output and the fiber serializer.
// PARAMETERS
//  sp_dw     8   width of sync_period register
//  sat_dw    8   width of saturation event counter
// PORTS
//  clk          in   1   ADC-domain clock; only clock
//  rst_n        in   1   reset, asynchronous assert, active-low
//  in_xy        in   18  signed field sample, X when in_iq=0, Y when in_iq=1
//  in_iq        in   1   local interleave flag (state[0] of local divider)
//  sync         in   1   one-cycle frame pulse, high when local state==7
//  link_en      in   1   host enable (external)
//  sync_period  in   sp_dw  qsync every sync_period+1 frames; 0 = every frame
//  test_mode    in   1   select test pattern (only with FIBER_TX_TESTPAT_EN)
//  sat_clr      in   1   single-cycle clear of sat_count
//  ser_ready    in   1   serializer/link up; level
//  iq_send      out  17  word to serializer
//  qsync_tx     out  1   frame marker, coincident with a Y word
//  tx_active    out  1   high in RUN
//  align_err    out  1   sticky: sync seen with in_iq!=1; cleared on leaving RUN
//  sat_count    out  sat_dw  saturating count of clipped samples
// BEHAVIOUR
//  Reset: iq_send=0, qsync_tx=0, tx_active=0, align_err=0, sat_count=0, FSM=IDLE, frm=0, pcnt=0.
//  Datapath, 2-cycle latency in_xy->iq_send; in_iq is delayed identically (d_iq).
//   - Stage 1: r = (in_xy+1)>>>1, computed 19-bit.
//   - Stage 2: if r>65535, emit 65535 and count saturation; r>=-65536 always holds.
//   - sat_count increments once per clipped sample, holds at all-ones; sat_clr wins over increment.
//  FSM:
//   - IDLE: outputs 0. ->ALIGN when link_en & ser_ready.
//   - ALIGN: outputs 0. ->RUN on the first delayed sync (sync delayed 2, aligned with data). Leave frm=0, pcnt=0 on entry to RUN.
//   - RUN: iq_send = stage-2 word. frm increments mod 8 and is reloaded to 0 by each delayed sync.
//     - qsync_tx=1 when frm==7, d_iq==1 and pcnt==0.
//     - pcnt: counts frames down from sync_period at frm==7 and reloads at 0.
//     - Far end sees qsync on a Y word; the next word is X.
//   - Any state ->IDLE within 1 cycle if link_en=0 or ser_ready=0. On that exit cycle iq_send and qsync_tx are already 0; no partial marker.
//  align_err: in RUN, if delayed sync arrives while d_iq==0, set align_err. Do not emit qsync while align_err=1; stay in RUN.
//  sync_period changes take effect at next pcnt reload.
//  Simultaneous events:
//   - sync and frm==7 on the same cycle: consistent case, no error.
//   - sync at frm!=7: frm reloads to 0 and align_err stays clear if d_iq==1; one frame shortened.
//  Reset mid-RUN returns to IDLE immediately (async); no marker emitted on release until ALIGN completes.
// CONFIGURATION
//  FIBER_TX_TESTPAT_EN defined:
//   - In RUN with test_mode=1, iq_send = 17-bit counter, incremented every word and reset to 0 on each emitted qsync.
//   - Framing, qsync and sat_count are unchanged; sat_count is not incremented by the pattern.
//  Undefined: test_mode ignored, no counter logic synthesized.
// STRUCTURE
//  Shared package/header:
//   - FSM state encodings IDLE=0, ALIGN=1, RUN=2.
//   - Frame length constant FRAME_LEN=8.
//   - X/Y meaning of iq (0=X).
//  One natural sub-module: fiber_iq_round_sat (18->17 round, saturate, sat flag, 1 pipeline stage).
//  FSM, frame/period counters and the test pattern stay in top.
// TESTING
//  1 rst_n low mid-RUN -> all outputs 0 same cycle; after release with link_en=1, ser_ready=1, no qsync_tx before first sync+2.
//  2 link up, sync every 8 cycles, sync_period=0:
//    - qsync_tx every 8 cycles on a Y word.
//    - Loopback into a state divider with sync_state=2 gives X words when iq=0.
//  3 sync_period=3 -> qsync_tx spacing exactly 32 cycles; change to 1 mid-run -> 16-cycle spacing after the next reload.
//  4 Rounding:
//    - in_xy=131071 -> iq_send=65535, sat_count+1.
//    - in_xy=-131072 -> -65536, no count.
//    - in_xy=3 -> 2; in_xy=-3 -> -1.
//    - 300 clips -> sat_count=255; sat_clr -> 0.
//  5 Sync injected with in_iq=0 aligned -> align_err=1, qsync_tx stops; drop ser_ready 1 cycle -> IDLE, align_err=0, re-aligns.
//  6 (FIBER_TX_TESTPAT_EN) test_mode=1, sync_period=0 -> iq_send counts 0..7 between markers, qsync_tx on word 7.

Source files
------------

// File: rtl/fiber_iq_tx_pkg.sv
// ---------------------------------------------------------------------------
// fiber_iq_tx_pkg
// Shared definitions for the fiber I/Q transmit slice: FSM state encoding,
// frame geometry and the meaning of the interleave (iq) flag.
// ---------------------------------------------------------------------------
package fiber_iq_tx_pkg;

  // Transmit FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } tx_state_t;

  // Words per frame; the far end's I/Q divider is 3 bits wide
  localparam int FRAME_LEN = 8;
  localparam int FRM_W     = $clog2(FRAME_LEN);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);

  // Interleave flag meaning: 0 = X component, 1 = Y component
  localparam logic IQ_X = 1'b0;
  localparam logic IQ_Y = 1'b1;

  // Sample widths: 18-bit field samples in, 17-bit words to the serializer
  localparam int XY_W   = 18;
  localparam int WORD_W = 17;

endpackage

// File: rtl/fiber_iq_tx_if.sv
// ---------------------------------------------------------------------------
// fiber_iq_tx_if
// Sample stream and serializer-side signals of the fiber I/Q transmitter.
//   in_xy     : signed field sample, X when in_iq=0, Y when in_iq=1
//   in_iq     : local interleave flag (state[0] of local divider)
//   sync      : one-cycle frame pulse, high when local state==7
//   ser_ready : serializer/link up (level)
//   iq_send   : 17-bit word to the serializer
//   qsync_tx  : frame marker, coincident with a Y word
// Modports: master = sample source / serializer side, slave = transmitter.
// ---------------------------------------------------------------------------
interface fiber_iq_tx_if;
  import fiber_iq_tx_pkg::*;

  logic signed [XY_W-1:0] in_xy;
  logic                   in_iq;
  logic                   sync;
  logic                   ser_ready;
  logic [WORD_W-1:0]      iq_send;
  logic                   qsync_tx;

  modport master (
    output in_xy, in_iq, sync, ser_ready,
    input  iq_send, qsync_tx
  );

  modport slave (
    input  in_xy, in_iq, sync, ser_ready,
    output iq_send, qsync_tx
  );

endinterface

// File: rtl/fiber_iq_round_sat.sv
// ---------------------------------------------------------------------------
// fiber_iq_round_sat
// Rounds an 18-bit signed sample to 17 bits ((x+1)>>>1) and saturates the
// single positive overflow case to +65535. One pipeline register holds the
// rounded value; saturation and the clip flag are decoded from it.
//   clk, rst_n : clock, async active-low reset
//   in_xy      : 18-bit signed sample
//   word       : 17-bit rounded/saturated word (valid one cycle after in_xy)
//   sat        : high while word is a clipped sample
// ---------------------------------------------------------------------------
module fiber_iq_round_sat
  import fiber_iq_tx_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [XY_W-1:0] in_xy,
  output logic [WORD_W-1:0]      word,
  output logic                   sat
);

  logic signed [XY_W:0]   sum;
  logic signed [XY_W-1:0] r_q;
  logic                   unused_sum_lsb;

  // Add the rounding half in 19 bits so +131071 cannot wrap; dropping the
  // LSB of the sum is the arithmetic shift by one.
  assign sum            = {in_xy[XY_W-1], in_xy} + {{XY_W{1'b0}}, 1'b1};
  assign unused_sum_lsb = sum[0];

  // Stage 1 register: rounded 18-bit value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= sum[XY_W:1];
    end
  end

  // Only +65536 can exceed the 17-bit range; the negative side never clips
  assign sat  = !r_q[XY_W-1] && (r_q[XY_W-2:WORD_W-1] != '0);
  assign word = sat ? {1'b0, {(WORD_W-1){1'b1}}} : r_q[WORD_W-1:0];

endmodule

// File: rtl/fiber_iq_tx.sv
// ---------------------------------------------------------------------------
// fiber_iq_tx
// Transmit end of the fiber I/Q link. Rounds/saturates interleaved X/Y
// samples to 17 bits (2-cycle latency), frames them on an 8-word grid and
// emits a qsync marker on a Y word every sync_period+1 frames.
// Ports:
//   clk, rst_n  : ADC-domain clock, async active-low reset
//   lnk         : fiber_iq_tx_if.slave (in_xy, in_iq, sync, ser_ready,
//                 iq_send, qsync_tx)
//   link_en     : host enable
//   sync_period : qsync every sync_period+1 frames (0 = every frame)
//   test_mode   : select counter test pattern (FIBER_TX_TESTPAT_EN builds)
//   sat_clr     : single-cycle clear of sat_count
//   tx_active   : high in RUN
//   align_err   : sticky, sync seen on an X word; cleared on leaving RUN
//   sat_count   : saturating count of clipped samples
// Optional feature macro: FIBER_TX_TESTPAT_EN (17-bit counter test pattern).
// ---------------------------------------------------------------------------
module fiber_iq_tx
  import fiber_iq_tx_pkg::*;
#(
  parameter int sp_dw  = 8,
  parameter int sat_dw = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  fiber_iq_tx_if.slave      lnk,
  input  logic              link_en,
  input  logic [sp_dw-1:0]  sync_period,
  input  logic              test_mode,
  input  logic              sat_clr,
  output logic              tx_active,
  output logic              align_err,
  output logic [sat_dw-1:0] sat_count
);

  tx_state_t         state, state_n;
  logic              link_ok;
  logic              run_out;
  logic              marker;
  logic [WORD_W-1:0] word1;
  logic              sat1;
  logic [WORD_W-1:0] word2;
  logic [WORD_W-1:0] word_sel;
  logic              iq1, sync1;
  logic              d_iq, dsync;
  logic [FRM_W-1:0]  frm;
  logic [sp_dw-1:0]  pcnt;

  assign link_ok = link_en & lnk.ser_ready;

  fiber_iq_round_sat u_round_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .in_xy (lnk.in_xy),
    .word  (word1),
    .sat   (sat1)
  );

  // Stage 2 of the datapath; in_iq and sync ride along so that d_iq and
  // dsync describe the word currently in word2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iq1   <= 1'b0;
      sync1 <= 1'b0;
      d_iq  <= 1'b0;
      dsync <= 1'b0;
      word2 <= '0;
    end else begin
      iq1   <= lnk.in_iq;
      sync1 <= lnk.sync;
      d_iq  <= iq1;
      dsync <= sync1;
      word2 <= word1;
    end
  end

  // Clipped samples are counted as they enter stage 2; clear beats count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (sat1 && (sat_count != '1)) begin
      sat_count <= sat_count + sat_dw'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and output qualification. Outputs are gated by link_ok
  // combinationally so that the cycle on which the link drops already
  // shows zero words and no partial marker.
  always_comb begin
    state_n = state;
    run_out = 1'b0;
    marker  = 1'b0;
    case (state)
      IDLE: begin
        if (link_ok) state_n = ALIGN;
      end
      ALIGN: begin
        if (!link_ok)   state_n = IDLE;
        else if (dsync) state_n = RUN;
      end
      RUN: begin
        if (!link_ok) begin
          state_n = IDLE;
        end else begin
          run_out = 1'b1;
          marker  = (frm == FRM_LAST) && (d_iq == IQ_Y) &&
                    (pcnt == '0) && !align_err;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame position and period countdown. Both sit at zero outside RUN so
  // RUN always starts on the word after the aligning sync with frm=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm  <= '0;
      pcnt <= '0;
    end else if (run_out) begin
      frm <= dsync ? '0 : frm + FRM_W'(1);
      if (frm == FRM_LAST) begin
        pcnt <= (pcnt == '0) ? sync_period : pcnt - sp_dw'(1);
      end
    end else begin
      frm  <= '0;
      pcnt <= '0;
    end
  end

  // A sync landing on an X word means the far end would divide wrongly;
  // flag it and hold it until the FSM leaves RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err <= 1'b0;
    end else if (state_n != RUN) begin
      align_err <= 1'b0;
    end else if ((state == RUN) && dsync && (d_iq == IQ_X)) begin
      align_err <= 1'b1;
    end
  end

`ifdef FIBER_TX_TESTPAT_EN
  logic [WORD_W-1:0] pat_cnt;

  // Test pattern counter restarts after each emitted marker so the far end
  // sees 0..7 between markers when every frame carries one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_cnt <= '0;
    end else if (run_out) begin
      pat_cnt <= marker ? '0 : pat_cnt + WORD_W'(1);
    end else begin
      pat_cnt <= '0;
    end
  end

  assign word_sel = test_mode ? pat_cnt : word2;
`else
  logic unused_test_mode;

  assign unused_test_mode = test_mode;
  assign word_sel         = word2;
`endif

  assign lnk.iq_send  = run_out ? word_sel : '0;
  assign lnk.qsync_tx = marker;
  assign tx_active    = (state == RUN);

endmodule
